// File: rtl/rh_temp_poll_scheduler.sv
// ---------------------------------------------------------------------------
// rh_temp_poll_scheduler
//   Sequencer for the HDC1000 I2C transaction engines. After enable it writes
//   the configuration register, reads DeviceID / ManufacturerID once, then
//   polls Temperature and Humidity every POLL_CYC clocks. T/H reads wait for
//   DRDY_n with a timeout; every engine start is guarded by an END timeout.
//
// Ports
//   CLK_50, RESET_N          clock, asynchronous active-low reset
//   ENABLE                   run level; 0 lets the current transaction finish
//   CONFIG[15:0]             value for configuration register (pointer 8'h02)
//   DRDY_n                   sensor data-ready (active low, synchronised)
//   WW_GO/WP_GO/RD_GO        engine start levels (one-hot)
//   WW_REG, WP_REG[7:0]      pointers for write-word / write-pointer engines
//   WW_DATA[15:0]            write-word payload
//   WW_END/WP_END/RD_END     engine done, held high while its GO is high
//   RD_DATA[15:0]            read result, valid while RD_END=1
//   TEMP_UP/DN, RH_UP/DN     alarm limits, raw sensor codes
//   DeviceID, ManufacturerID, Temperature, Humidity  result registers
//   TEMP_ALARM, RH_ALARM     registered out-of-window flags
//   DATA_VALID               1-clock pulse once a T/H pair is complete
//   TMO_ERR                  sticky timeout flag, cleared only by reset
//   STATE[3:0]               current FSM state, for debug
// ---------------------------------------------------------------------------
module rh_temp_poll_scheduler #(
  parameter int GAP_CYC  = 8,
  parameter int POLL_CYC = 50_000_000,
  parameter int DRDY_TMO = 1_000_000,
  parameter int ENG_TMO  = 250_000
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [15:0] CONFIG,
  input  logic        DRDY_n,
  output logic        WW_GO,
  output logic        WP_GO,
  output logic        RD_GO,
  output logic [7:0]  WW_REG,
  output logic [7:0]  WP_REG,
  output logic [15:0] WW_DATA,
  input  logic        WW_END,
  input  logic        WP_END,
  input  logic        RD_END,
  input  logic [15:0] RD_DATA,
  input  logic [15:0] TEMP_UP,
  input  logic [15:0] TEMP_DN,
  input  logic [15:0] RH_UP,
  input  logic [15:0] RH_DN,
  output logic [15:0] DeviceID,
  output logic [15:0] ManufacturerID,
  output logic [15:0] Temperature,
  output logic [15:0] Humidity,
  output logic        TEMP_ALARM,
  output logic        RH_ALARM,
  output logic        DATA_VALID,
  output logic        TMO_ERR,
  output logic [3:0]  STATE
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CFG   = 4'd1,
    S_PTR   = 4'd2,
    S_DRDY  = 4'd3,
    S_READ  = 4'd4,
    S_GAP   = 4'd5,
    S_NEXT  = 4'd6,
    S_SLEEP = 4'd7
  } state_t;

  // Where GAP goes once its idle time has elapsed.
  typedef enum logic [2:0] {
    T_CFG  = 3'd0,
    T_PTR  = 3'd1,
    T_READ = 3'd2,
    T_DRDY = 3'd3,
    T_NEXT = 3'd4
  } tgt_t;

  state_t      state;
  tgt_t        gap_tgt;
  logic [1:0]  idx;          // 0 DevID, 1 MfrID, 2 Temp, 3 Hum
  logic [31:0] cnt;          // shared: engine wait, GAP, DRDY wait, SLEEP
  logic [15:0] cfg_shadow;
  logic        cfg_dirty;
  logic        t_upd;        // Temperature stored last clock -> refresh alarm
  logic        h_upd;
  logic        h_fresh;      // Humidity stored during this round
  logic        go_any;
  logic        end_ok;

  function automatic logic [7:0] ptr_of(input logic [1:0] i);
    case (i)
      2'd0:    ptr_of = 8'hFF;
      2'd1:    ptr_of = 8'hFE;
      2'd2:    ptr_of = 8'h00;
      default: ptr_of = 8'h01;
    endcase
  endfunction

  assign go_any = WW_GO | WP_GO | RD_GO;
  assign STATE  = state;

  // END counts only while the matching GO flop is already high, so an END
  // still high from a previous transaction at the GO-rise edge is ignored.
  always_comb begin
    end_ok = 1'b0;
    case (state)
      S_CFG:   end_ok = WW_GO & WW_END;
      S_PTR:   end_ok = WP_GO & WP_END;
      S_READ:  end_ok = RD_GO & RD_END;
      default: end_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      gap_tgt        <= T_CFG;
      idx            <= '0;
      cnt            <= '0;
      cfg_shadow     <= '0;
      cfg_dirty      <= 1'b0;
      t_upd          <= 1'b0;
      h_upd          <= 1'b0;
      h_fresh        <= 1'b0;
      WW_GO          <= 1'b0;
      WP_GO          <= 1'b0;
      RD_GO          <= 1'b0;
      WW_REG         <= '0;
      WP_REG         <= '0;
      WW_DATA        <= '0;
      DeviceID       <= '0;
      ManufacturerID <= '0;
      Temperature    <= '0;
      Humidity       <= '0;
      TEMP_ALARM     <= 1'b0;
      RH_ALARM       <= 1'b0;
      DATA_VALID     <= 1'b0;
      TMO_ERR        <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      t_upd      <= 1'b0;
      h_upd      <= 1'b0;

      // Alarms follow the store by one clock, so they compare the new value.
      if (t_upd) TEMP_ALARM <= (Temperature > TEMP_UP) | (Temperature < TEMP_DN);
      if (h_upd) RH_ALARM   <= (Humidity > RH_UP) | (Humidity < RH_DN);

      case (state)
        S_IDLE: begin
          if (ENABLE) begin
            idx        <= 2'd0;
            cfg_shadow <= CONFIG;
            cfg_dirty  <= 1'b0;
            WW_REG     <= 8'h02;
            WW_DATA    <= CONFIG;
            state      <= S_CFG;
          end
        end

        // Engine states: REG/DATA were loaded on entry, so the first clock
        // here raises GO one clock after the pointer/payload settled.
        S_CFG, S_PTR, S_READ: begin
          if (!go_any) begin
            cnt   <= '0;
            WW_GO <= (state == S_CFG);
            WP_GO <= (state == S_PTR);
            RD_GO <= (state == S_READ);
          end else if (end_ok) begin
            WW_GO <= 1'b0;
            WP_GO <= 1'b0;
            RD_GO <= 1'b0;
            cnt   <= '0;
            state <= S_GAP;
            case (state)
              S_CFG:   gap_tgt <= T_PTR;
              S_PTR:   gap_tgt <= idx[1] ? T_DRDY : T_READ;
              default: gap_tgt <= T_NEXT;
            endcase
            if (state == S_READ) begin
              case (idx)
                2'd0: DeviceID       <= RD_DATA;
                2'd1: ManufacturerID <= RD_DATA;
                2'd2: begin
                  Temperature <= RD_DATA;
                  t_upd       <= 1'b1;
                end
                default: begin
                  Humidity <= RD_DATA;
                  h_upd    <= 1'b1;
                  h_fresh  <= 1'b1;
                end
              endcase
            end
          end else if (cnt == 32'(ENG_TMO - 1)) begin
            // Engine hung: abandon it and restart from configuration so the
            // IDs are re-read once the bus is healthy again.
            WW_GO   <= 1'b0;
            WP_GO   <= 1'b0;
            RD_GO   <= 1'b0;
            TMO_ERR <= 1'b1;
            cnt     <= '0;
            idx     <= 2'd0;
            gap_tgt <= T_CFG;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_GAP: begin
          if (cnt == 32'(GAP_CYC - 1)) begin
            cnt <= '0;
            if (!ENABLE) begin
              state <= S_IDLE;
            end else begin
              case (gap_tgt)
                T_CFG: begin
                  cfg_shadow <= CONFIG;
                  cfg_dirty  <= 1'b0;
                  WW_REG     <= 8'h02;
                  WW_DATA    <= CONFIG;
                  state      <= S_CFG;
                end
                T_PTR: begin
                  WP_REG <= ptr_of(idx);
                  state  <= S_PTR;
                end
                T_READ:  state <= S_READ;
                T_DRDY:  state <= S_DRDY;
                default: state <= S_NEXT;
              endcase
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_DRDY: begin
          if (!DRDY_n) begin
            cnt   <= '0;
            state <= S_READ;
          end else if (cnt == 32'(DRDY_TMO - 1)) begin
            // Skip this read: the old value and its alarm stay in place.
            TMO_ERR <= 1'b1;
            cnt     <= '0;
            state   <= S_NEXT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        S_NEXT: begin
          if (idx == 2'd3) begin
            DATA_VALID <= h_fresh;
            h_fresh    <= 1'b0;
            cnt        <= '0;
            state      <= S_SLEEP;
          end else begin
            idx    <= idx + 2'd1;
            WP_REG <= ptr_of(idx + 2'd1);
            state  <= S_PTR;
          end
        end

        S_SLEEP: begin
          if (CONFIG != cfg_shadow) cfg_dirty <= 1'b1;
          if (!ENABLE) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == 32'(POLL_CYC - 1)) begin
            cnt <= '0;
            idx <= 2'd2;
            // Also catch a CONFIG change landing on the very last clock.
            if (cfg_dirty || (CONFIG != cfg_shadow)) begin
              cfg_shadow <= CONFIG;
              cfg_dirty  <= 1'b0;
              WW_REG     <= 8'h02;
              WW_DATA    <= CONFIG;
              state      <= S_CFG;
            end else begin
              WP_REG <= ptr_of(2'd2);
              state  <= S_PTR;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
